memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Responder side of the cache/request interface. Accepts `imemREN`, `dmemREN` and `dmemWEN` requests from the request unit, serializes them onto a single shared RAM port, and answers each with a one-cycle `ihit`/`dhit` pulse carrying load data. It sits between the datapath's request unit and the RAM model, and turns variable-latency RAM handshakes (`ramstate`) into the hit protocol the request unit consumes.

## Interface
- `DATA_W`, 32, width of addresses, store data and load data (matches `word_t`)
- `ERR_LOAD`, 32'hBAD1BAD1, load value returned when RAM reports ERROR
- `CLK  in  1  single clock, rising edge`
- `RST  in  1  reset, asynchronous, active-high`
- `imemREN  in  1  instruction read request (level, held until ihit)`
- `imemaddr  in  DATA_W  instruction address`
- `dmemREN  in  1  data read request (level, held until dhit)`
- `dmemWEN  in  1  data write request (level, held until dhit)`
- `dmemaddr  in  DATA_W  data address`
- `dmemstore  in  DATA_W  data write value`
- `ihit  out  1  one-cycle pulse: instruction transaction complete`
- `dhit  out  1  one-cycle pulse: data transaction complete`
- `imemload  out  DATA_W  instruction read data, valid while ihit=1`
- `dmemload  out  DATA_W  data read data, valid while dhit=1`
- `ramREN / ramWEN  out  1  RAM read / write strobes`
- `ramaddr  out  DATA_W  RAM address`
- `ramstore  out  DATA_W  RAM write data`
- `ramload  in  DATA_W  RAM read data, valid when ramstate=ACCESS`
- `ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR`

## Operation
- FSM states are IDLE, IBUSY, DBUSY, DONE_I and DONE_D.
- IDLE: sample the requests and grant one transaction.
  - Data request = `dmemREN | dmemWEN`.
  - If both the data and instruction requests are pending, grant the side not served last (`last_d` flag). Otherwise grant whichever is pending.
  - On grant, latch addr, store data and op (read/write) into the request registers. Go to IBUSY or DBUSY.
  - `dmemWEN & dmemREN` together is treated as a write.
- IBUSY/DBUSY: drive the RAM from the latched registers, never from the live inputs.
  - `ramREN` = 1 for reads; `ramWEN` = 1 for writes. Never both.
  - Stay while ramstate is FREE or BUSY.
  - On ACCESS, capture `ramload` and go to DONE_x.
  - On ERROR, capture `ERR_LOAD` and go to DONE_x.
- DONE_I/DONE_D: assert the matching hit for exactly one cycle, with the captured load on `imemload`/`dmemload`. Update `last_d`, then return to IDLE.
  - RAM strobes are 0 in DONE states.
- Requests dropped mid-transaction do not abort it. The RAM access completes and the hit still pulses.
- Outside DONE states the load outputs hold their last captured value.

## Timing
- Reset values:
  - State = IDLE, `last_d` = 0 (first contended grant goes to data).
  - All hits and RAM strobes = 0; `ramaddr`, `ramstore`, `imemload`, `dmemload` = 0.
- Latency: request seen in IDLE at cycle 0 → RAM driven from cycle 1 → ACCESS at cycle k≥1 → hit at cycle k+1. Minimum is 2 cycles.
- The arbiter is back in IDLE the cycle after the hit. Since the requester drops REN on hit, the next request is granted at the earliest 1 cycle after the hit.
- Throughput: one transaction per 3 cycles with a zero-wait RAM.
- Both hits are never asserted in the same cycle.
- RST asserted mid-transaction: the FSM returns to IDLE immediately, strobes drop asynchronously, no hit is issued, and the latched request is discarded.

## Configuration
- `MEMORY_ARBITER_PERF_EN`: when defined, adds three outputs.
  - `icount` (32): completed instruction transactions.
  - `dcount` (32): completed data transactions.
  - `stall_cycles` (32): cycles spent in IBUSY/DBUSY with ramstate≠ACCESS.
  - All reset to 0 and wrap modulo 2^32.
- Without the macro, these ports and the counter logic are absent. Core behaviour is identical either way.

## Structure
- `cpu_types_pkg` holds:
  - `word_t`, and `ramstate_t` (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - New `arb_state_t` enum covering IDLE, IBUSY, DBUSY, DONE_I, DONE_D.
- One sub-module, `memory_arbiter_perf`, holds the counters. It is instantiated only under `MEMORY_ARBITER_PERF_EN` and is fed the state and ramstate.

## Test plan
- Instruction read, RAM ACCESS on first cycle: imemaddr=0x40, ramload=0x2402000A → ihit at cycle 2 with imemload=0x2402000A; dhit stays 0.
- Data write with 2 BUSY cycles: dmemWEN=1, addr=0x80, store=0xDEADBEEF → ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF held for cycles 1–3, ACCESS at cycle 3, dhit at cycle 4.
- Contention: imemREN and dmemREN held together from reset → data served first, then instruction, then data. Hits alternate dhit, ihit, dhit.
- ERROR response: dmemREN, ramstate=ERROR → dhit pulses with dmemload=0xBAD1BAD1; next request accepted normally.
- RST pulse during DBUSY → strobes 0 immediately, no dhit; after release a fresh imemREN completes in 2 cycles.
- With `MEMORY_ARBITER_PERF_EN`: 3 instruction reads and 2 data reads, one BUSY cycle each → icount=3, dcount=2, stall_cycles=5.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: word/ramstate types, arbiter FSM states
// and the default load value returned on a RAM error.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IBUSY  = 3'd1,
    DBUSY  = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  localparam word_t ERR_LOAD_DEFAULT = 32'hBAD1BAD1;

  function automatic logic is_ram_busy(arb_state_t s);
    return (s == IBUSY) || (s == DBUSY);
  endfunction
endpackage

// File: rtl/memory_arbiter_if.sv
// Request-unit and RAM-side signals of the memory arbiter. slave = arbiter view,
// master = environment view (request unit plus RAM model).
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  // Handshake: imemREN / dmemREN / dmemWEN are levels held by the requester
  // until the matching one-cycle ihit / dhit pulse; a hit is the only completion.
  logic       imemREN;
  word_t      imemaddr;
  logic       dmemREN;
  logic       dmemWEN;
  word_t      dmemaddr;
  word_t      dmemstore;
  logic       ihit;
  logic       dhit;
  word_t      imemload;
  word_t      dmemload;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ramstate_t  ramstate;
  arb_state_t arb_state;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
    output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, arb_state
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
    input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, arb_state
  );
endinterface

// File: rtl/memory_arbiter_perf.sv
// Transaction and stall counters for the memory arbiter (built only with
// MEMORY_ARBITER_PERF_EN). All counters wrap modulo 2^32.
module memory_arbiter_perf
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  arb_state_t state,
  input  ramstate_t  ramstate,
  output word_t      icount,
  output word_t      dcount,
  output word_t      stall_cycles
);
  word_t icount_q, icount_d;
  word_t dcount_q, dcount_d;
  word_t stall_q, stall_d;

  always_comb begin
    icount_d = icount_q;
    dcount_d = dcount_q;
    stall_d  = stall_q;
    if (state == DONE_I) icount_d = icount_q + 32'd1;
    if (state == DONE_D) dcount_d = dcount_q + 32'd1;
    if (is_ram_busy(state) && (ramstate != ACCESS)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stall_q  <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
      stall_q  <= stall_d;
    end
  end

  assign icount       = icount_q;
  assign dcount       = dcount_q;
  assign stall_cycles = stall_q;
endmodule

// File: rtl/memory_arbiter.sv
// Serializes instruction and data requests onto one RAM port and answers each
// with a one-cycle ihit/dhit. Optional counters: MEMORY_ARBITER_PERF_EN.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    DATA_W   = 32,
  parameter word_t ERR_LOAD = ERR_LOAD_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  memory_arbiter_if.slave   bus
`ifdef MEMORY_ARBITER_PERF_EN
  ,
  output word_t             icount,
  output word_t             dcount,
  output word_t             stall_cycles
`endif
);
  arb_state_t        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              d_req;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    d_req    = bus.dmemREN | bus.dmemWEN;
    unique case (state_q)
      IDLE: begin
        // Under contention the side not served last wins; WEN beats REN.
        if (d_req && (!bus.imemREN || !last_d_q)) begin
          state_d = DBUSY;
          addr_d  = bus.dmemaddr;
          store_d = bus.dmemstore;
          wr_d    = bus.dmemWEN;
        end else if (bus.imemREN) begin
          state_d = IBUSY;
          addr_d  = bus.imemaddr;
          store_d = '0;
          wr_d    = 1'b0;
        end
      end
      IBUSY: begin
        if (bus.ramstate == ACCESS) begin
          iload_d = bus.ramload;
          state_d = DONE_I;
        end else if (bus.ramstate == ERROR) begin
          iload_d = ERR_LOAD;
          state_d = DONE_I;
        end
      end
      DBUSY: begin
        if (bus.ramstate == ACCESS) begin
          dload_d = bus.ramload;
          state_d = DONE_D;
        end else if (bus.ramstate == ERROR) begin
          dload_d = ERR_LOAD;
          state_d = DONE_D;
        end
      end
      DONE_I: begin
        last_d_d = 1'b0;
        state_d  = IDLE;
      end
      DONE_D: begin
        last_d_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  // Strobes decode the registered state only, so reset drops them asynchronously.
  assign bus.ramREN    = is_ram_busy(state_q) & ~wr_q;
  assign bus.ramWEN    = is_ram_busy(state_q) & wr_q;
  assign bus.ramaddr   = addr_q;
  assign bus.ramstore  = store_q;
  assign bus.ihit      = (state_q == DONE_I);
  assign bus.dhit      = (state_q == DONE_D);
  assign bus.imemload  = iload_q;
  assign bus.dmemload  = dload_q;
  assign bus.arb_state = state_q;

`ifdef MEMORY_ARBITER_PERF_EN
  memory_arbiter_perf u_perf (
    .CLK          (CLK),
    .RST          (RST),
    .state        (state_q),
    .ramstate     (bus.ramstate),
    .icount       (icount),
    .dcount       (dcount),
    .stall_cycles (stall_cycles)
  );
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected hits into a queue,
// a negedge monitor pops and compares them against every ihit/dhit pulse.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  memory_arbiter_if bus ();

`ifdef MEMORY_ARBITER_PERF_EN
  word_t icount, dcount, stall_cycles;
`endif

  memory_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef MEMORY_ARBITER_PERF_EN
    ,
    .icount       (icount),
    .dcount       (dcount),
    .stall_cycles (stall_cycles)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RAM model: BUSY for busy_cfg strobe cycles, then ACCESS (or ERROR)
  int   busy_cfg;
  logic err_cfg;
  logic ovr_en;
  word_t ovr_data;
  int   wait_cnt;

  always_comb begin
    bus.ramstate = FREE;
    bus.ramload  = ovr_en ? ovr_data : {16'hA5A5, bus.ramaddr[15:0]};
    if (bus.ramREN || bus.ramWEN) begin
      if (wait_cnt < busy_cfg) bus.ramstate = BUSY;
      else if (err_cfg)        bus.ramstate = ERROR;
      else                     bus.ramstate = ACCESS;
    end
  end

  always @(posedge CLK) begin
    if (bus.ramREN || bus.ramWEN) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  // scoreboard
  int n_pass;
  int n_total;
  logic [33:0] exp_q[$];  // {is_d, check_data, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    logic [33:0] e;
    if (bus.ihit || bus.dhit) begin
      chk("single_hit", {31'd0, bus.ihit & bus.dhit}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_hit", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("hit_side", {31'd0, bus.dhit}, {31'd0, e[33]});
        if (e[32]) chk("hit_data", bus.dhit ? bus.dmemload : bus.imemload, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic drop_reqs();
    bus.imemREN = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic run_txn(input logic is_d, input logic wr, input word_t addr, input word_t store,
                         input int busy, input logic err, input logic chk_data, input word_t exp_data);
    int   n;
    logic done;
    busy_cfg = busy;
    err_cfg  = err;
    if (is_d) begin
      bus.dmemaddr  = addr;
      bus.dmemstore = store;
      bus.dmemWEN   = wr;
      bus.dmemREN   = ~wr;
    end else begin
      bus.imemaddr = addr;
      bus.imemREN  = 1'b1;
    end
    exp_q.push_back({is_d, chk_data, exp_data});
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (is_d ? bus.dhit : bus.ihit) begin
        done = 1'b1;
        chk("done_strobes", {31'd0, bus.ramREN | bus.ramWEN}, 32'd0);
      end else begin
        chk("ram_ren", {31'd0, bus.ramREN}, {31'd0, ~wr});
        chk("ram_wen", {31'd0, bus.ramWEN}, {31'd0, wr});
        chk("ram_addr", bus.ramaddr, addr);
        if (wr) chk("ram_store", bus.ramstore, store);
        if (n == 1) begin
          // live inputs change after grant; RAM must keep the latched request
          bus.imemaddr  = ~addr;
          bus.dmemaddr  = ~addr;
          bus.dmemstore = ~store;
        end
      end
    end
    chk("latency", n, 2 + busy);
    drop_reqs();
    @(posedge CLK); #1;
  endtask

  // directed sequence
  int cyc;
  int hits;
  int last_hit;
`ifdef MEMORY_ARBITER_PERF_EN
  word_t ic0, dc0, sc0;
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    busy_cfg = 0;
    err_cfg = 1'b0;
    ovr_en = 1'b0;
    ovr_data = '0;
    bus.imemaddr = '0;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    drop_reqs();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", {29'd0, bus.arb_state}, {29'd0, IDLE});
    chk("rst_hits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    chk("rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_dmemload", bus.dmemload, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // contention from reset: data, instruction, data, three cycles apart
    bus.imemaddr = 32'h100;
    bus.dmemaddr = 32'h200;
    bus.imemREN = 1'b1;
    bus.dmemREN = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 32'hA5A50200});
    exp_q.push_back({1'b0, 1'b1, 32'hA5A50100});
    exp_q.push_back({1'b1, 1'b1, 32'hA5A50200});
    cyc = 0;
    hits = 0;
    last_hit = 0;
    while (hits < 3 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (bus.ihit || bus.dhit) begin
        hits++;
        chk("contend_gap", cyc - last_hit, (hits == 1) ? 32'd2 : 32'd3);
        last_hit = cyc;
      end
    end
    chk("contend_hits", hits, 32'd3);
    drop_reqs();
    @(posedge CLK); #1;

    // instruction read, zero-wait RAM
    ovr_en = 1'b1;
    ovr_data = 32'h2402000A;
    run_txn(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b1, 32'h2402000A);
    ovr_en = 1'b0;

    // data write with two BUSY cycles
    run_txn(1'b1, 1'b1, 32'h80, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);

    // data read answered with ERROR, then a normal read
    run_txn(1'b1, 1'b0, 32'h90, 32'h0, 0, 1'b1, 1'b1, 32'hBAD1BAD1);
    run_txn(1'b1, 1'b0, 32'h94, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50094);
    chk("imemload_held", bus.imemload, 32'h2402000A);

    // reset pulse in DBUSY: strobes drop at once, no hit follows
    busy_cfg = 5;
    err_cfg = 1'b0;
    bus.dmemaddr = 32'h300;
    bus.dmemREN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("pre_rst_state", {29'd0, bus.arb_state}, {29'd0, DBUSY});
    chk("pre_rst_ren", {31'd0, bus.ramREN}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("async_state", {29'd0, bus.arb_state}, {29'd0, IDLE});
    chk("async_ramaddr", bus.ramaddr, 32'd0);
    drop_reqs();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    run_txn(1'b0, 1'b0, 32'h44, 32'h0, 0, 1'b0, 1'b1, 32'hA5A50044);

    // three instruction and two data reads, one BUSY cycle each
`ifdef MEMORY_ARBITER_PERF_EN
    ic0 = icount;
    dc0 = dcount;
    sc0 = stall_cycles;
`endif
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50010);
    run_txn(1'b0, 1'b0, 32'h14, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50014);
    run_txn(1'b0, 1'b0, 32'h18, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50018);
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50020);
    run_txn(1'b1, 1'b0, 32'h24, 32'h0, 1, 1'b0, 1'b1, 32'hA5A50024);
`ifdef MEMORY_ARBITER_PERF_EN
    chk("perf_icount", icount - ic0, 32'd3);
    chk("perf_dcount", dcount - dc0, 32'd2);
    chk("perf_stall", stall_cycles - sc0, 32'd5);
`endif

    repeat (4) @(posedge CLK);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
